// File: rtl/alu_issue_queue.sv
// ----------------------------------------------------------------------------
// alu_issue_queue
//
// In-order issue buffer between the decoder and the ALU pipeline stage.
// Decoded micro-ops are written into a circular FIFO and issued one per
// cycle, oldest first, whenever the ALU pipeline is not busy. The issue
// strobe and issued micro-op are registered. The decoder is stalled while
// the queue is full.
//
// Optional feature (macro ALU_ISSUE_BYPASS_EN):
//   When defined, a micro-op offered to an empty queue while the ALU is not
//   busy and no flush is requested goes straight into the issue register
//   (issued the next cycle). It is never written to storage. When undefined,
//   every micro-op passes through storage (minimum issue latency 2 cycles).
//
// Parameters:
//   DEPTH  number of entries, power of two, at least 2
//   PTR_W  pointer width, derived from DEPTH (do not override)
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   reset_n       asynchronous active-low reset
//   flush         synchronous flush: empties the queue, cancels issue/push
//   dec_valid     decoder offers dec_mop this cycle
//   dec_mop       offered micro-op
//   dec_stall     queue full, decoder must hold dec_mop
//   alu_busy      ALU pipeline busy, no issue this cycle
//   alu_in_ready  one-cycle strobe, alu_mop valid this cycle
//   alu_mop       issued micro-op (holds its value between strobes)
//   count         occupancy, 0..DEPTH
// ----------------------------------------------------------------------------

package DecoderTypes;

    typedef struct packed {
        logic [7:0]  tag;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } micro_op_t;

endpackage

module alu_issue_queue
    import DecoderTypes::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           flush,
    input  logic           dec_valid,
    input  micro_op_t      dec_mop,
    output logic           dec_stall,
    input  logic           alu_busy,
    output logic           alu_in_ready,
    output micro_op_t      alu_mop,
    output logic [PTR_W:0] count
);

    localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    micro_op_t        mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             alu_in_ready_q, alu_in_ready_d;
    micro_op_t        alu_mop_q, alu_mop_d;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic empty;
    logic full;
    logic push;
    logic pop;
    logic bypass;
    logic store;

    assign empty = (count_q == '0);
    assign full  = (count_q == FullCount);

    // Registered-count compare only: a full queue stalls even if it pops.
    assign dec_stall = full;

    // Flush wins over both a same-cycle pop and a same-cycle push.
    assign pop  = !empty && !alu_busy && !flush;
    assign push = dec_valid && !full && !flush;

`ifdef ALU_ISSUE_BYPASS_EN
    // Empty queue and free ALU: skip storage and issue next cycle.
    assign bypass = empty && dec_valid && !alu_busy && !flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed micro-op is accepted but never occupies an entry.
    assign store = push && !bypass;

    // ------------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------------
    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        alu_in_ready_d = 1'b0;
        alu_mop_d      = alu_mop_q;

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // pop and bypass are mutually exclusive (bypass requires empty).
            if (pop) begin
                head_d         = head_q + 1'b1;
                alu_in_ready_d = 1'b1;
                alu_mop_d      = mem_q[head_q];
            end else if (bypass) begin
                alu_in_ready_d = 1'b1;
                alu_mop_d      = dec_mop;
            end

            if (store) begin
                tail_d = tail_q + 1'b1;
            end

            case ({store, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            alu_in_ready_q <= 1'b0;
            alu_mop_q      <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            alu_in_ready_q <= alu_in_ready_d;
            alu_mop_q      <= alu_mop_d;
        end
    end

    // Entry storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_q[tail_q] <= dec_mop;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign alu_in_ready = alu_in_ready_q;
    assign alu_mop      = alu_mop_q;
    assign count        = count_q;

    // ------------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------------
    count_in_range: assert property (
        @(posedge clk) disable iff (!reset_n) count_q <= FullCount
    );

    // Occupancy is exactly the pointer distance, except when full (distance 0).
    count_matches_ptrs: assert property (
        @(posedge clk) disable iff (!reset_n)
        (PTR_W'(count_q) == PTR_W'(tail_q - head_q))
    );

    // An issue strobe is only ever produced from a non-busy cycle.
    issue_not_from_busy: assert property (
        @(posedge clk) disable iff (!reset_n)
        alu_in_ready_q |-> $past(!alu_busy && !flush)
    );

endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;
    import DecoderTypes::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned PTR_W = $clog2(DEPTH);
`ifdef ALU_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic           clk       = 1'b0;
    logic           reset_n   = 1'b0;
    logic           flush     = 1'b0;
    logic           dec_valid = 1'b0;
    logic           alu_busy  = 1'b0;
    micro_op_t      dec_mop   = '0;
    logic           dec_stall;
    logic           alu_in_ready;
    micro_op_t      alu_mop;
    logic [PTR_W:0] count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int n_issued = 0;

    // Reference model: queue of stored mops, scoreboard of issued mops.
    micro_op_t mq[$];
    micro_op_t sb[$];
    bit        exp_rdy = 1'b0;
    micro_op_t hold    = '0;

    always #5 clk = ~clk;

    alu_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .dec_valid    (dec_valid),
        .dec_mop      (dec_mop),
        .dec_stall    (dec_stall),
        .alu_busy     (alu_busy),
        .alu_in_ready (alu_in_ready),
        .alu_mop      (alu_mop),
        .count        (count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO semantics stated at queue level, sampled at each rising edge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            sb.delete();
            exp_rdy = 1'b0;
        end else begin
            int sz;
            sz = mq.size();
            exp_rdy = 1'b0;
            if (!flush) begin
                if (BYP && sz == 0 && dec_valid && !alu_busy) begin
                    sb.push_back(dec_mop);
                    exp_rdy = 1'b1;
                end else begin
                    if (sz != 0 && !alu_busy) begin
                        sb.push_back(mq.pop_front());
                        exp_rdy = 1'b1;
                    end
                    if (dec_valid && sz != DEPTH) mq.push_back(dec_mop);
                end
            end else begin
                mq.delete();
            end
        end
    end

    // Monitor: compares DUT outputs with the model away from the active edge.
    always @(negedge clk) begin
        if (!reset_n) hold = '0;
        check("count", 64'(count), 64'(mq.size()));
        check("dec_stall", 64'(dec_stall), 64'(mq.size() == DEPTH));
        check("alu_in_ready", 64'(alu_in_ready), 64'(exp_rdy));
        if (alu_in_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_issue: got mop %0h expected no issue at %0t",
                         alu_mop, $time);
            end else begin
                micro_op_t m;
                m = sb.pop_front();
                check("alu_mop", 64'(alu_mop), 64'(m));
                hold = m;
                n_issued++;
            end
        end else begin
            if (exp_rdy && sb.size() != 0) void'(sb.pop_front());
            check("alu_mop_hold", 64'(alu_mop), 64'(hold));
        end
    end

    function automatic micro_op_t rand_mop(input logic [7:0] tag);
        micro_op_t m;
        m.tag    = tag;
        m.opcode = 7'($urandom);
        m.rd     = 5'($urandom);
        m.rs1    = 5'($urandom);
        m.rs2    = 5'($urandom);
        m.imm    = $urandom;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit b, input bit f, input logic [7:0] tag);
        dec_valid = v;
        alu_busy  = b;
        flush     = f;
        dec_mop   = rand_mop(tag);
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        // Power-on reset.
        #1;
        check("rst_count", 64'(count), 64'(0));
        check("rst_ready", 64'(alu_in_ready), 64'(0));
        check("rst_stall", 64'(dec_stall), 64'(0));
        check("rst_mop", 64'(alu_mop), 64'(0));
        @(posedge clk);
        #3 reset_n = 1'b1;
        tick();

        // Reset mid-burst: 3 held entries, then asynchronous reset.
        base = n_issued;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 8'(1 + i));
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_count", 64'(count), 64'(0));
        check("async_rst_ready", 64'(alu_in_ready), 64'(0));
        check("async_rst_stall", 64'(dec_stall), 64'(0));
        check("async_rst_mop", 64'(alu_mop), 64'(0));
        @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
        drive(1'b1, 1'b0, 1'b0, 8'h04);
        idle(4);
        check("rst_issued", 64'(n_issued - base), 64'(1));

        // Fill while busy, 9th offer must be refused, then drain in order.
        base = n_issued;
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b1, 1'b0, 8'(16 + i));
        drive(1'b1, 1'b1, 1'b0, 8'hF0);
        drive(1'b1, 1'b1, 1'b0, 8'hF0);
        check("full_count", 64'(count), 64'(DEPTH));
        check("full_stall", 64'(dec_stall), 64'(1));
        idle(DEPTH + 4);
        check("fill_issued", 64'(n_issued - base), 64'(DEPTH));

        // Throughput: one push per cycle, ALU always free.
        base = n_issued;
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'b0, 8'(i));
        idle(4);
        check("stream_issued", 64'(n_issued - base), 64'(20));

        // Wrap-around: 3 rounds of push 6 / drain 6.
        base = n_issued;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0, 8'(32 + r * 6 + i));
            idle(8);
        end
        check("wrap_issued", 64'(n_issued - base), 64'(18));

        // Busy gaps with 4 entries queued.
        base = n_issued;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 8'(64 + i));
        for (int i = 0; i < 8; i++) drive(1'b0, (i % 2) == 0, 1'b0, 8'h00);
        idle(3);
        check("gap_issued", 64'(n_issued - base), 64'(4));

        // Flush with 5 queued and a same-cycle push: nothing must issue.
        base = n_issued;
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 8'(80 + i));
        drive(1'b1, 1'b0, 1'b1, 8'hEE);
        check("flush_count", 64'(count), 64'(0));
        idle(4);
        check("flush_issued", 64'(n_issued - base), 64'(0));

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 31) == 0, 8'($urandom));
        end
        idle(DEPTH + 4);
        check("sb_drained", 64'(sb.size()), 64'(0));
        check("final_count", 64'(count), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
